vga_config_loader: RTL

Register-write front end that sits directly upstream of the VGA timing generator and pattern generator. It takes the slow, asynchronous pin-level write strobe and its address/data bus, and synchronizes them into the pixel clock domain. Writes go into shadow registers, which are committed atomically to the active timing outputs at a frame boundary, so the generator never sees a half-updated mode.

---
 rtl/vga_config_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vga_config_loader.sv
// vga_config_loader: synchronizes a slow pin-level register write port into the
// pixel clock domain. Timing writes land in shadow registers and are committed
// atomically at a frame boundary, or on demand. Pattern and colour writes take
// effect immediately.
module vga_config_loader #(
    parameter int          SYNC_STAGES  = 2,
    parameter int unsigned DEF_HDISPLAY = 640,
    parameter int unsigned DEF_VDISPLAY = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_strobe,
    input  logic [3:0]  wr_addr,
    input  logic [2:0]  wr_hi,
    input  logic [7:0]  wr_data,
    input  logic        frame_start,
    output logic [11:0] hdisplay,
    output logic [9:0]  hfrontporch,
    output logic [9:0]  hsynclength,
    output logic [9:0]  hbackporch,
    output logic        hsyncpolarity,
    output logic [11:0] vdisplay,
    output logic [7:0]  vfrontporch,
    output logic [7:0]  vsynclength,
    output logic [7:0]  vbackporch,
    output logic        vsyncpolarity,
    output logic [4:0]  pattern,
    output logic [5:0]  color_in,
    output logic        pending,
    output logic [7:0]  wr_count
);

    typedef struct packed {
        logic [11:0] hdisplay;
        logic [9:0]  hfrontporch;
        logic [9:0]  hsynclength;
        logic [9:0]  hbackporch;
        logic        hsyncpolarity;
        logic [11:0] vdisplay;
        logic [7:0]  vfrontporch;
        logic [7:0]  vsynclength;
        logic [7:0]  vbackporch;
        logic        vsyncpolarity;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        hdisplay:      12'(DEF_HDISPLAY),
        hfrontporch:   10'd16,
        hsynclength:   10'd96,
        hbackporch:    10'd48,
        hsyncpolarity: 1'b0,
        vdisplay:      12'(DEF_VDISPLAY),
        vfrontporch:   8'd10,
        vsynclength:   8'd2,
        vbackporch:    8'd33,
        vsyncpolarity: 1'b0
    };

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   hist_q;
    logic                   synced;
    logic                   warm;
    logic                   accept;

    timing_t    shadow_q, shadow_d, active_q;
    logic [4:0] pattern_q, pattern_d;
    logic [5:0] color_q, color_d;
    logic       pending_q;
    logic [7:0] count_q;
    logic       timing_wr;
    logic       force_commit;
    logic       commit;

    assign synced = sync_q[SYNC_STAGES-1];
    assign warm   = warm_q[SYNC_STAGES-1];
    assign accept = synced & ~hist_q;
    assign commit = force_commit | (frame_start & pending_q);

    // Strobe synchronizer and rising-edge history. Until the synchronizer has
    // filled after reset, history is held at 1 so a strobe already high at
    // reset release must fall and rise again before it counts as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            warm_q <= '0;
            hist_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge values, which is what makes this a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], wr_strobe};
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            hist_q <= synced | ~warm;
        end
    end

    // Write decode: next shadow, pattern and colour values for this cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        shadow_d     = shadow_q;
        pattern_d    = pattern_q;
        color_d      = color_q;
        timing_wr    = 1'b0;
        force_commit = 1'b0;
        if (accept) begin
            unique case (wr_addr)
                4'd0: begin shadow_d.hdisplay = {1'b0, wr_hi, wr_data}; timing_wr = 1'b1; end
                4'd1: begin shadow_d.hfrontporch = {wr_hi[1:0], wr_data}; timing_wr = 1'b1; end
                4'd2: begin
                    shadow_d.hsyncpolarity = wr_hi[2];
                    shadow_d.hsynclength   = {wr_hi[1:0], wr_data};
                    timing_wr              = 1'b1;
                end
                4'd3: begin shadow_d.hbackporch = {wr_hi[1:0], wr_data}; timing_wr = 1'b1; end
                4'd4: begin shadow_d.vdisplay = {1'b0, wr_hi, wr_data}; timing_wr = 1'b1; end
                4'd5: begin shadow_d.vfrontporch = wr_data; timing_wr = 1'b1; end
                4'd6: begin
                    shadow_d.vsyncpolarity = wr_hi[2];
                    shadow_d.vsynclength   = wr_data;
                    timing_wr              = 1'b1;
                end
                4'd7:  begin shadow_d.vbackporch = wr_data; timing_wr = 1'b1; end
                4'd8:  color_d   = wr_data[5:0];
                4'd9:  pattern_d = wr_data[4:0];
                4'd10: pattern_d = pattern_q + 5'd1;
                4'd11: pattern_d = pattern_q - 5'd1;
                4'd12: force_commit = 1'b1;
                4'd15: begin
                    shadow_d  = DEF_TIMING;
                    pattern_d = 5'd31;
                    color_d   = 6'd0;
                    timing_wr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Register state; a commit copies the pre-write shadow, and a timing write
    // in the same cycle keeps pending set so it commits at the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= DEF_TIMING;
            active_q  <= DEF_TIMING;
            pattern_q <= 5'd31;
            color_q   <= 6'd0;
            pending_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            shadow_q  <= shadow_d;
            pattern_q <= pattern_d;
            color_q   <= color_d;
            if (commit)
                active_q <= shadow_q;
            if (timing_wr)
                pending_q <= 1'b1;
            else if (commit)
                pending_q <= 1'b0;
            if (accept)
                count_q <= count_q + 8'd1;
        end
    end

    assign hdisplay      = active_q.hdisplay;
    assign hfrontporch   = active_q.hfrontporch;
    assign hsynclength   = active_q.hsynclength;
    assign hbackporch    = active_q.hbackporch;
    assign hsyncpolarity = active_q.hsyncpolarity;
    assign vdisplay      = active_q.vdisplay;
    assign vfrontporch   = active_q.vfrontporch;
    assign vsynclength   = active_q.vsynclength;
    assign vbackporch    = active_q.vbackporch;
    assign vsyncpolarity = active_q.vsyncpolarity;
    assign pattern       = pattern_q;
    assign color_in      = color_q;
    assign pending       = pending_q;
    assign wr_count      = count_q;

endmodule
